// File: rtl/wb_uart_tx.sv
// Wishbone pipelined-mode UART transmitter: a byte FIFO drained by a bit-serial 8N1 engine.
// Define WB_UART_TX_PARITY_EN to append an even-parity bit to each frame (8E1).
module wb_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [2:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef WB_UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   div_q, div_d;
    logic          ack_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   bit_div_q, bit_div_d;
    logic          tx_q, tx_d;
`ifdef WB_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic [1:0]  addr_sel;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        busy;
    logic [3:0]  count_sat;
    logic [15:0] eff_div;
    logic        unused_bits;

    assign unused_bits = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data[31:16], i_wb_sel[2]};

    assign addr_sel   = i_wb_addr[3:2];
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != ST_IDLE);
    assign eff_div    = (div_q < 16'd2) ? 16'd2 : div_q;

    // Only DATA writes can stall; a pop on the same edge does not release it.
    assign o_wb_stall = i_wb_stb & i_wb_we & (addr_sel == ADDR_DATA) & fifo_full;
    assign accept     = i_wb_stb & ~o_wb_stall;
    assign push       = accept & i_wb_we & (addr_sel == ADDR_DATA) & i_wb_sel[0];

    always_comb begin
        if (32'(count_q) > 32'd15) begin
            count_sat = 4'hF;
        end else begin
            count_sat = 4'(count_q);
        end
    end

    always_comb begin
        rdata_d = 32'h0;
        div_d   = div_q;
        if (accept && !i_wb_we) begin
            case (addr_sel)
                ADDR_STATUS: rdata_d = {24'h0, count_sat, 1'b0, busy, fifo_empty, fifo_full};
                ADDR_DIV:    rdata_d = {16'h0, div_q};
                default:     rdata_d = 32'h0;
            endcase
        end
        if (accept && i_wb_we && (addr_sel == ADDR_DIV)) begin
            if (i_wb_sel[0]) div_d[7:0]  = i_wb_data[7:0];
            if (i_wb_sel[1]) div_d[15:8] = i_wb_data[15:8];
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        bit_div_d = bit_div_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef WB_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    bit_div_d = eff_div;
                    baud_d    = eff_div - 16'd1;
                    tx_d      = 1'b0;
                    state_d   = ST_START;
`ifdef WB_UART_TX_PARITY_EN
                    parity_d  = ^fifo_mem[rd_ptr_q];
`endif
                end
            end
            ST_START: begin
                if (baud_q == 16'd0) begin
                    baud_d    = bit_div_q - 16'd1;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = bit_div_q - 16'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef WB_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_q == 16'd0) begin
                    baud_d  = bit_div_q - 16'd1;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_wb_data[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            div_q     <= 16'(DEFAULT_DIV);
            ack_q     <= 1'b0;
            rdata_q   <= 32'h0;
            state_q   <= ST_IDLE;
            shift_q   <= 8'h0;
            bit_cnt_q <= 3'd0;
            baud_q    <= 16'd0;
            bit_div_q <= 16'd2;
            tx_q      <= 1'b1;
`ifdef WB_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            div_q     <= div_d;
            ack_q     <= accept;
            rdata_q   <= rdata_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            bit_div_q <= bit_div_d;
            tx_q      <= tx_d;
`ifdef WB_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_data = rdata_q;
    assign o_tx      = tx_q;

endmodule
